// File: rtl/arb_rr_8t1_sel_if.sv
// Handshake bundle between up to eight requesters/consumer and the round-robin
// select arbiter that steers the downstream 8:1 data mux.
interface arb_rr_8t1_sel_if;
    logic [7:0] REQ;
    logic       DONE;
    logic [2:0] SEL;
    logic [7:0] GNT;
    logic       VALID;
    logic       TOUT;

    // Requester/consumer side: drives requests and completion, observes the grant.
    modport master (
        output REQ,
        output DONE,
        input  SEL,
        input  GNT,
        input  VALID,
        input  TOUT
    );

    // Arbiter side.
    modport slave (
        input  REQ,
        input  DONE,
        output SEL,
        output GNT,
        output VALID,
        output TOUT
    );
endinterface

// File: rtl/arb_rr_8t1_sel.sv
// Round-robin arbiter producing the registered 3-bit select for an 8:1 mux.
// Optional forced-release timeout is enabled by defining ARB_TIMEOUT_EN.
module arb_rr_8t1_sel #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    arb_rr_8t1_sel_if.slave      bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255 || (64'd1 << CW) <= 64'(TIMEOUT)) begin : g_bad_cfg
        $error("arb_rr_8t1_sel: TIMEOUT must be 2..255 and fit in CW bits");
    end

    state_t     state, state_nxt;
    logic [2:0] sel_q, sel_nxt;
    logic [7:0] gnt_q, gnt_nxt;
    logic       valid_q, valid_nxt;
    logic [2:0] last_q, last_nxt;
    logic [2:0] pick;
    logic       found;
    logic       release_c;

    // Scan starts one past the last winner so that winner ends up lowest priority.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            logic [2:0] idx;
            idx = last_q + 3'(i);
            if (!found && bus.REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign release_c = bus.DONE | ~bus.REQ[sel_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          tout_q, tout_nxt;

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        gnt_nxt   = gnt_q;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        tout_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick;
                    gnt_nxt   = 8'b1 << pick;
                    valid_nxt = 1'b1;
                    last_nxt  = pick;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end else if (cnt_q == TLIM) begin
                    // Forced release keeps LAST, so the hog drops to lowest priority.
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    tout_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            tout_q <= tout_nxt;
        end
    end

    assign bus.TOUT = tout_q;
`else
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        gnt_nxt   = gnt_q;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick;
                    gnt_nxt   = 8'b1 << pick;
                    valid_nxt = 1'b1;
                    last_nxt  = pick;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.TOUT = 1'b0;
`endif

    // SEL is deliberately left untouched on release so the mux output stays steady.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 3'd7;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            gnt_q   <= gnt_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
        end
    end

    assign bus.SEL   = sel_q;
    assign bus.GNT   = gnt_q;
    assign bus.VALID = valid_q;

endmodule

// File: tb/tb_arb_rr_8t1_sel.sv
// Directed bench for arb_rr_8t1_sel; timeout expectations follow ARB_TIMEOUT_EN.
module tb_arb_rr_8t1_sel;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_fail;

    arb_rr_8t1_sel_if bus ();

    arb_rr_8t1_sel #(.TIMEOUT(4), .CW(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [2:0] ch);
        logic [7:0] onehot;
        onehot = 8'b1 << ch;
        check({tag, ".valid"}, 32'(bus.VALID), 32'd1);
        check({tag, ".sel"},   32'(bus.SEL),   32'(ch));
        check({tag, ".gnt"},   32'(bus.GNT),   32'(onehot));
    endtask

    task automatic check_idle(input string tag, input logic [2:0] sel_hold);
        check({tag, ".valid"}, 32'(bus.VALID), 32'd0);
        check({tag, ".gnt"},   32'(bus.GNT),   32'd0);
        check({tag, ".sel"},   32'(bus.SEL),   32'(sel_hold));
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        RST      = 1'b1;
        bus.REQ  = 8'h00;
        bus.DONE = 1'b0;

        // 1: reset, single request, DONE release
        step();
        step();
        check_idle("rst", 3'd0);
        check("rst.tout", 32'(bus.TOUT), 32'd0);
        RST     = 1'b0;
        bus.REQ = 8'h01;
        step();
        check_grant("single", 3'd0);
        bus.DONE = 1'b1;
        step();
        check_idle("single_rel", 3'd0);
        bus.DONE = 1'b0;
        bus.REQ  = 8'h00;

        // DONE while idle has no effect
        bus.DONE = 1'b1;
        step();
        check_idle("done_idle", 3'd0);
        bus.DONE = 1'b0;

        // 2: full fairness from LAST=7
        RST = 1'b1;
        step();
        RST     = 1'b0;
        bus.REQ = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_grant($sformatf("rr%0d", k), 3'(k % 8));
            bus.DONE = 1'b1;
            step();
            check_idle($sformatf("rr%0d_bubble", k), 3'(k % 8));
            bus.DONE = 1'b0;
        end
        bus.REQ = 8'h00;
        step();

        // 3: wrap and skip (LAST=0 now)
        bus.REQ = 8'h40;
        step();
        check_grant("ch6", 3'd6);
        bus.DONE = 1'b1;
        step();
        check_idle("ch6_rel", 3'd6);
        bus.DONE = 1'b0;
        bus.REQ  = 8'h41;
        step();
        check_grant("wrap", 3'd0);
        bus.DONE = 1'b1;
        step();
        bus.DONE = 1'b0;
        bus.REQ  = 8'h00;
        step();

        // 4: simultaneous DONE and withdrawal
        bus.REQ = 8'h08;
        step();
        check_grant("ch3", 3'd3);
        bus.REQ  = 8'h20;
        bus.DONE = 1'b1;
        step();
        check_idle("simul_rel", 3'd3);
        bus.DONE = 1'b0;
        step();
        check_grant("after_simul", 3'd5);
        bus.REQ = 8'h00;
        step();
        check_idle("withdraw", 3'd5);

        // 5: timeout behaviour with TIMEOUT=4 (LAST=5)
        bus.REQ = 8'h08;
        step();
        check_grant("to_g0", 3'd3);
        for (int k = 1; k < 4; k++) begin
            step();
            check_grant($sformatf("to_g%0d", k), 3'd3);
            check($sformatf("to_g%0d.tout", k), 32'(bus.TOUT), 32'd0);
        end
        step();
`ifdef ARB_TIMEOUT_EN
        check_idle("to_fire", 3'd3);
        check("to_fire.tout", 32'(bus.TOUT), 32'd1);
`else
        check_grant("to_hold", 3'd3);
        check("to_hold.tout", 32'(bus.TOUT), 32'd0);
`endif
        step();
        check_grant("to_regrant", 3'd3);
        check("to_regrant.tout", 32'(bus.TOUT), 32'd0);
        bus.REQ = 8'h00;
        step();

        // 6: reset during a grant to channel 5 (LAST=3)
        bus.REQ = 8'h20;
        step();
        check_grant("ch5", 3'd5);
        RST = 1'b1;
        step();
        check_idle("rst_mid", 3'd0);
        check("rst_mid.tout", 32'(bus.TOUT), 32'd0);
        RST     = 1'b0;
        bus.REQ = 8'hA0;
        step();
        check_grant("post_rst", 3'd5);
        bus.DONE = 1'b1;
        step();
        bus.DONE = 1'b0;
        step();
        check_grant("post_rst_next", 3'd7);
        bus.REQ = 8'h00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
